imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BIG_ENDIAN, default 1, meaning: 1 places the first received byte of each word in bits [31:24]; 0 places it in bits [7:0].
REQ-002 Parameter ADDR_WIDTH, default 12, meaning: width of the imem word address and the word count.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-006 word_count  input  ADDR_WIDTH  number of 32-bit words to load; sampled on accepted start.
REQ-007 byte_valid  input  1  source has a byte on byte_data.
REQ-008 byte_data  input  8  program byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 imem_address  output  ADDR_WIDTH  imem word address for the write.
REQ-011 imem_data  output  32  assembled instruction word.
REQ-012 imem_wren  output  1  imem write enable, one cycle per word.
REQ-013 processor_reset  output  1  held high while the program is absent or being loaded.
REQ-014 busy  output  1  high in COLLECT and WRITE.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, WRITE and DONE, all registered.
REQ-017 In IDLE, start=1 with word_count!=0 SHALL latch word_count, clear the word address and byte index, and move to COLLECT next cycle.
REQ-018 In IDLE, start=1 with word_count=0 SHALL move directly to DONE without any imem write.
REQ-019 byte_ready SHALL be 1 only in COLLECT; a byte is accepted on any cycle with byte_valid=1 and byte_ready=1.
REQ-020 The byte_valid=1/byte_ready=0 case SHALL leave all state unchanged and SHALL drop no byte.
REQ-021 Each accepted byte SHALL be stored in the assembly register at the lane selected by BIG_ENDIAN and the 2-bit byte index, and the index SHALL then increment.
REQ-022 Acceptance of the fourth byte (index 3) SHALL move the FSM to WRITE and wrap the index to 0.
REQ-023 In WRITE, imem_wren SHALL be 1 for exactly one cycle, with imem_address equal to the current word address and imem_data equal to the assembled word.
REQ-024 The write SHALL occur in the cycle immediately after the fourth byte is accepted (1-cycle latency).
REQ-025 After WRITE the FSM SHALL go to DONE if the word just written was number word_count-1; otherwise it SHALL increment the word address and return to COLLECT.
REQ-026 The word address SHALL never wrap; the maximum word_count is 2^ADDR_WIDTH-1 and the last address written is word_count-1.
REQ-027 In DONE, done SHALL be 1 and processor_reset SHALL be 0, and both SHALL hold until reset or start.
REQ-028 start in DONE SHALL reassert processor_reset in the next cycle and SHALL restart the load exactly as REQ-017/REQ-018 do.
REQ-029 start in COLLECT or WRITE SHALL be ignored.
REQ-030 imem_address and imem_data SHALL hold their last values while imem_wren=0; only imem_wren qualifies them.
REQ-031 processor_reset SHALL be 1 in IDLE, COLLECT and WRITE.

Reset
REQ-032 reset=1 SHALL force, in the next cycle, state=IDLE, byte_ready=0, imem_wren=0, busy=0, done=0, processor_reset=1, imem_address=0, imem_data=0, byte index=0 and latched count=0.
REQ-033 reset during COLLECT or WRITE SHALL abort the load in the next cycle with no further imem write; any partially assembled word is discarded.
REQ-034 reset has priority over start, byte_valid and every FSM transition in the same cycle.

Verification
REQ-035 Stimulus: reset, start with word_count=2, bytes 0x20,0x01,0x00,0x05,0x00,0x00,0x00,0x08 sent back-to-back. Required response: writes 0x20010005@0 and 0x00000008@1; done=1 and processor_reset=0 the cycle after the second write.
REQ-036 Stimulus: BIG_ENDIAN=0, word_count=1, bytes 0x11,0x22,0x33,0x44. Required response: single write of 0x44332211@0.
REQ-037 Stimulus: word_count=1 with byte_valid toggled 1/0 at random, plus a start pulse mid-load. Required response: exactly four bytes accepted, one write, the start pulse ignored.
REQ-038 Stimulus: start with word_count=0. Required response: done=1 one cycle after start, with imem_wren never asserted.
REQ-039 Stimulus: reset asserted after the second byte of a load with word_count=3, then a fresh load with word_count=1. Required response: no write from the aborted load; the fresh word is written at address 0.
REQ-040 Stimulus: start in DONE. Required response: processor_reset=1 and done=0 the next cycle, followed by a complete reload.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into 32-bit words and writes them
// to imem, holding the processor in reset until the whole program is present.
//
// state   | meaning
// IDLE    | no program loaded yet, waiting for start
// COLLECT | assembling the current word from incoming bytes
// WRITE   | one-cycle imem write of the assembled word
// DONE    | program loaded, processor released
module imem_loader #(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  processor_reset,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            byte_idx;
  logic [1:0]            lane;
  logic [31:0]           asm_word;
  logic [31:0]           asm_next;
  logic                  accept;
  logic                  start_ok;
  logic                  last_word;

  assign accept    = byte_valid && (state == COLLECT);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  // count_q is never zero while a word is being written, so this cannot underflow
  assign last_word = (word_addr == (count_q - ONE));
  assign lane      = BIG_ENDIAN ? (2'd3 - byte_idx) : byte_idx;

  always_comb begin
    asm_next = asm_word;
    asm_next[{lane, 3'b000} +: 8] = byte_data;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (word_count != '0) ? COLLECT : DONE;
      COLLECT:    if (byte_valid && (byte_idx == 2'd3)) state_next = WRITE;
      WRITE:      state_next = last_word ? DONE : COLLECT;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      word_addr    <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
      imem_address <= '0;
      imem_data    <= '0;
    end else begin
      if (start_ok) begin
        count_q   <= word_count;
        word_addr <= '0;
        byte_idx  <= '0;
      end
      if (accept) begin
        asm_word <= asm_next;
        byte_idx <= byte_idx + 2'd1;
        // Output registers only move on a completed word so they hold between writes
        if (byte_idx == 2'd3) begin
          imem_address <= word_addr;
          imem_data    <= asm_next;
        end
      end
      if ((state == WRITE) && !last_word) word_addr <= word_addr + ONE;
    end
  end

  assign byte_ready      = (state == COLLECT);
  assign imem_wren       = (state == WRITE);
  assign busy            = (state == COLLECT) || (state == WRITE);
  assign done            = (state == DONE);
  assign processor_reset = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: big-endian and little-endian instances share
// the same stimulus; writes and accepted bytes are logged on the falling edge.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;

  logic        byte_ready, imem_wren, processor_reset, busy, done;
  logic [11:0] imem_address;
  logic [31:0] imem_data;

  logic        le_ready, le_wren, le_preset, le_busy, le_done;
  logic [11:0] le_address;
  logic [31:0] le_data;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [31:0] wr_data_q[$];
  logic [11:0] wr_addr_q[$];
  logic [31:0] le_data_q[$];
  logic [11:0] le_addr_q[$];

  always #5 clock = ~clock;

  imem_loader #(.BIG_ENDIAN(1'b1), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_address(imem_address), .imem_data(imem_data), .imem_wren(imem_wren),
    .processor_reset(processor_reset), .busy(busy), .done(done));

  imem_loader #(.BIG_ENDIAN(1'b0), .ADDR_WIDTH(12)) dut_le (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_ready),
    .imem_address(le_address), .imem_data(le_data), .imem_wren(le_wren),
    .processor_reset(le_preset), .busy(le_busy), .done(le_done));

  always @(negedge clock) begin
    if (imem_wren) begin
      wr_data_q.push_back(imem_data);
      wr_addr_q.push_back(imem_address);
    end
    if (le_wren) begin
      le_data_q.push_back(le_data);
      le_addr_q.push_back(le_address);
    end
    if (byte_valid && byte_ready) acc_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [11:0] wc);
    start = 1'b1;
    word_count = wc;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // returns #1 after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (byte_ready) begin
        @(posedge clock);
        #1 byte_valid = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout byte=%h not accepted", b);
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL wait_done_timeout done=%b required 1", done); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
    checks++; if (imem_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", imem_wren); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (processor_reset !== 1'b1) begin failures++; $display("FAIL reset_preset got=%b exp=1", processor_reset); end
    checks++; if (imem_address !== 12'h000 || imem_data !== 32'h0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h exp=000/00000000", imem_address, imem_data);
    end
  endtask

  task automatic test_big_endian_two_words();
    logic [7:0] bytes [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    int base = wr_data_q.size();
    do_reset();
    pulse_start(12'd2);
    checks++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin failures++; $display("FAIL be_collect got busy=%b ready=%b exp=1/1", busy, byte_ready); end
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    checks++; if (imem_wren !== 1'b1 || imem_address !== 12'd0 || imem_data !== 32'h20010005) begin
      failures++; $display("FAIL be_write0 got wren=%b %h@%h exp 1 20010005@000", imem_wren, imem_data, imem_address);
    end
    for (int i = 4; i < 8; i++) send_byte(bytes[i]);
    checks++; if (imem_wren !== 1'b1 || imem_address !== 12'd1 || imem_data !== 32'h00000008) begin
      failures++; $display("FAIL be_write1 got wren=%b %h@%h exp 1 00000008@001", imem_wren, imem_data, imem_address);
    end
    @(posedge clock); #1;
    checks++; if (done !== 1'b1 || processor_reset !== 1'b0 || imem_wren !== 1'b0) begin
      failures++; $display("FAIL be_done got done=%b preset=%b wren=%b exp 1/0/0", done, processor_reset, imem_wren);
    end
    checks++; if (imem_address !== 12'd1 || imem_data !== 32'h00000008) begin
      failures++; $display("FAIL be_hold got %h@%h exp 00000008@001", imem_data, imem_address);
    end
    checks++; if (wr_data_q.size() != base + 2) begin
      failures++; $display("FAIL be_write_count got=%0d exp=2", wr_data_q.size() - base);
    end
  endtask

  task automatic test_little_endian();
    int base = le_data_q.size();
    int bbase = wr_data_q.size();
    do_reset();
    pulse_start(12'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done();
    checks++; if (le_data_q.size() != base + 1) begin
      failures++; $display("FAIL le_write_count got=%0d exp=1", le_data_q.size() - base);
    end else if (le_data_q[base] !== 32'h44332211 || le_addr_q[base] !== 12'd0) begin
      checks++; failures++; $display("FAIL le_word got %h@%h exp 44332211@000", le_data_q[base], le_addr_q[base]);
    end else checks++;
    checks++; if (wr_data_q.size() != bbase + 1 || wr_data_q[bbase] !== 32'h11223344) begin
      failures++; $display("FAIL be_same_bytes got count=%0d exp 1 word 11223344", wr_data_q.size() - bbase);
    end
  endtask

  task automatic test_throttle_and_ignored_start();
    logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int base = wr_data_q.size();
    int abase;
    do_reset();
    abase = acc_cnt;
    pulse_start(12'd1);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        @(posedge clock); #1;
      end
      if (i == 2) pulse_start(12'd5);
      send_byte(bytes[i]);
    end
    wait_done();
    byte_valid = 1'b1;
    byte_data = 8'h99;
    repeat (3) @(posedge clock);
    #1 byte_valid = 1'b0;
    checks++; if (acc_cnt - abase != 4) begin failures++; $display("FAIL thr_accepted got=%0d exp=4", acc_cnt - abase); end
    checks++; if (wr_data_q.size() != base + 1 || wr_data_q[base] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL thr_write got count=%0d exp 1 word DEADBEEF", wr_data_q.size() - base);
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL thr_done got done=%b busy=%b exp 1/0", done, busy); end
  endtask

  task automatic test_zero_count();
    int base = wr_data_q.size();
    do_reset();
    pulse_start(12'd0);
    checks++; if (done !== 1'b1 || processor_reset !== 1'b0) begin
      failures++; $display("FAIL zero_done got done=%b preset=%b exp 1/0", done, processor_reset);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++; if (wr_data_q.size() != base) begin failures++; $display("FAIL zero_no_write got=%0d writes exp=0", wr_data_q.size() - base); end
  endtask

  task automatic test_abort_then_reload();
    int base = wr_data_q.size();
    do_reset();
    pulse_start(12'd3);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h77;
    @(posedge clock);
    #1 reset = 1'b0;
    byte_valid = 1'b0;
    checks++; if (busy !== 1'b0 || byte_ready !== 1'b0 || processor_reset !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL abort_state got busy=%b ready=%b preset=%b done=%b exp 0/0/1/0", busy, byte_ready, processor_reset, done);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (wr_data_q.size() != base) begin failures++; $display("FAIL abort_no_write got=%0d exp=0", wr_data_q.size() - base); end
    pulse_start(12'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_done();
    checks++; if (wr_data_q.size() != base + 1 || wr_data_q[base] !== 32'hAABBCCDD || wr_addr_q[base] !== 12'd0) begin
      failures++; $display("FAIL abort_reload got count=%0d exp 1 word AABBCCDD@000", wr_data_q.size() - base);
    end
  endtask

  task automatic test_restart_from_done();
    int base = wr_data_q.size();
    pulse_start(12'd1);
    checks++; if (processor_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_state got preset=%b done=%b busy=%b exp 1/0/1", processor_reset, done, busy);
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done();
    checks++; if (wr_data_q.size() != base + 1 || wr_data_q[base] !== 32'h01020304 || wr_addr_q[base] !== 12'd0) begin
      failures++; $display("FAIL restart_reload got count=%0d exp 1 word 01020304@000", wr_data_q.size() - base);
    end
    checks++; if (processor_reset !== 1'b0) begin failures++; $display("FAIL restart_release got preset=%b exp=0", processor_reset); end
  endtask

  initial begin
    test_reset();
    test_big_endian_two_words();
    test_little_endian();
    test_throttle_and_ignored_start();
    test_zero_count();
    test_abort_then_reload();
    test_restart_from_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
